// File: rtl/biquad8_zero_coeff_ctrl.sv
// Coefficient load sequencer for the biquad8_single_zero_fir numerator stage.
// A bus master stages b and a, then commits; the block replays them into the
// FIR serial load port as write b, write a, update, with optional settling gaps.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no sequence active, waiting for a commit
// WR_B   | coeff_wr_o high, coeff_dat_o = shadow b
// GAP_B  | settling after b write, WR_GAP cycles (skipped when WR_GAP=0)
// WR_A   | coeff_wr_o high, coeff_dat_o = shadow a
// GAP_A  | settling after a write, WR_GAP cycles (skipped when WR_GAP=0)
// UPD    | coeff_update_o and done_o high; restarts directly if a commit is queued
module biquad8_zero_coeff_ctrl #(
    parameter int COEFF_BITS = 18,
    parameter int WR_GAP     = 0,
    parameter int ADDR_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_i,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [COEFF_BITS-1:0] dat_i,
    output logic [COEFF_BITS-1:0] coeff_dat_o,
    output logic                  coeff_wr_o,
    output logic                  coeff_update_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pending_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_B  = 3'd1,
        S_GAP_B = 3'd2,
        S_WR_A  = 3'd3,
        S_GAP_A = 3'd4,
        S_UPD   = 3'd5
    } state_t;

    // Gap timer counts down from WR_GAP-1 to zero, so a gap state lasts WR_GAP cycles.
    localparam logic [3:0] GAP_LOAD = 4'((WR_GAP > 0) ? WR_GAP - 1 : 0);
    localparam logic       HAS_GAP  = (WR_GAP > 0);

    state_t                 state_q, state_d;
    logic [3:0]             gap_q, gap_d;
    logic                   pending_q, pending_d;
    logic [COEFF_BITS-1:0]  stg_b_q, stg_a_q;
    logic [COEFF_BITS-1:0]  shd_b_q, shd_b_d;
    logic [COEFF_BITS-1:0]  shd_a_q, shd_a_d;
    logic [COEFF_BITS-1:0]  coeff_dat_q, coeff_dat_d;
    logic                   coeff_wr_q, coeff_wr_d;
    logic                   coeff_update_q, coeff_update_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic commit;
    logic stage_b;
    logic stage_a;
    logic start;

    assign commit  = wr_i && (addr_i == ADDR_BITS'(2));
    assign stage_b = wr_i && (addr_i == ADDR_BITS'(0));
    assign stage_a = wr_i && (addr_i == ADDR_BITS'(1));

    // Staging registers accept writes at any time; address 3 is silently dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_b_q <= '0;
            stg_a_q <= '0;
        end else begin
            if (stage_b) stg_b_q <= dat_i;
            if (stage_a) stg_a_q <= dat_i;
        end
    end

    // Next-state, shadow capture, pending queue and registered-output preparation.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        pending_d = pending_q;
        shd_b_d   = shd_b_q;
        shd_a_d   = shd_a_q;
        start     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (commit) start = 1'b1;
            end
            S_WR_B: begin
                if (HAS_GAP) begin
                    state_d = S_GAP_B;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = S_WR_A;
                end
            end
            S_GAP_B: begin
                if (gap_q == 4'd0) state_d = S_WR_A;
                else               gap_d   = gap_q - 4'd1;
            end
            S_WR_A: begin
                if (HAS_GAP) begin
                    state_d = S_GAP_A;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = S_UPD;
                end
            end
            S_GAP_A: begin
                if (gap_q == 4'd0) state_d = S_UPD;
                else               gap_d   = gap_q - 4'd1;
            end
            S_UPD: begin
                // A commit arriving in the last cycle is treated like a queued one.
                if (pending_q || commit) start = 1'b1;
                else                     state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Repeated commits while busy collapse into a single queued restart.
        if (commit && (state_q != S_IDLE) && (state_q != S_UPD)) pending_d = 1'b1;

        if (start) begin
            state_d   = S_WR_B;
            shd_b_d   = stg_b_q;
            shd_a_d   = stg_a_q;
            pending_d = 1'b0;
        end

        coeff_wr_d     = (state_d == S_WR_B) || (state_d == S_WR_A);
        coeff_update_d = (state_d == S_UPD);
        done_d         = (state_d == S_UPD);
        busy_d         = (state_d != S_IDLE);
        if (state_d == S_WR_B)      coeff_dat_d = shd_b_d;
        else if (state_d == S_WR_A) coeff_dat_d = shd_a_d;
        else                        coeff_dat_d = coeff_dat_q;
    end

    // State, shadows and output registers; reset aborts any sequence without an update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            gap_q          <= '0;
            pending_q      <= 1'b0;
            shd_b_q        <= '0;
            shd_a_q        <= '0;
            coeff_dat_q    <= '0;
            coeff_wr_q     <= 1'b0;
            coeff_update_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            pending_q      <= pending_d;
            shd_b_q        <= shd_b_d;
            shd_a_q        <= shd_a_d;
            coeff_dat_q    <= coeff_dat_d;
            coeff_wr_q     <= coeff_wr_d;
            coeff_update_q <= coeff_update_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign coeff_dat_o    = coeff_dat_q;
    assign coeff_wr_o     = coeff_wr_q;
    assign coeff_update_o = coeff_update_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pending_o      = pending_q;

endmodule
